axi_stream_header_arbiter: RTL and testbench
============================================

Name: axi_stream_header_arbiter

Overview:
- Arbitrates several independent header requesters onto the single insert-header channel of the header-insertion datapath.
- Uses round-robin priority.
- Holds the grant for a whole packet: from header acceptance until the packet's last data beat is seen on the datapath's input stream.
- Sits between the header sources and the inserter, and passively monitors the inserter's data-input handshake.

Parameters:
- DATA_WD, 32, data/header width in bits
- DATA_BYTE_WD, DATA_WD/8, byte lanes
- BYTE_CNT_WD, $clog2(DATA_BYTE_WD), width of byte_insert_cnt
- NUM_REQ, 4, number of header requesters (2..8)
- REQ_ID_WD, $clog2(NUM_REQ), grant index width
- PKT_CNT_WD, 16, completed-packet counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- req_valid  in  NUM_REQ  per-requester header valid
- req_data  in  NUM_REQ*DATA_WD  packed headers, requester i at [i*DATA_WD +: DATA_WD]
- req_keep  in  NUM_REQ*DATA_BYTE_WD  packed header keeps
- req_byte_cnt  in  NUM_REQ*BYTE_CNT_WD  packed byte counts
- req_ready  out  NUM_REQ  one-hot accept pulse to the winning requester
- valid_insert  out  1  header valid to inserter
- data_insert  out  DATA_WD  registered header
- keep_insert  out  DATA_BYTE_WD  registered keep
- byte_insert_cnt  out  BYTE_CNT_WD  registered byte count
- ready_insert  in  1  inserter accepts header
- mon_valid_in  in  1  monitored inserter valid_in
- mon_ready_in  in  1  monitored inserter ready_in
- mon_last_in  in  1  monitored inserter last_in
- grant_id  out  REQ_ID_WD  index of current owner
- busy  out  1  high in OFFER or WAIT_PKT
- pkt_cnt  out  PKT_CNT_WD  completed packets, wraps

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous, active-low.
- Reset values: state=IDLE, rr_ptr=0, valid_insert=0, data/keep/byte_cnt=0, req_ready=0, grant_id=0, busy=0, pkt_cnt=0.
- last_evt = mon_valid_in & mon_ready_in & mon_last_in.

IDLE:
- If any req_valid is high, the winner is the first set bit searching from rr_ptr upward with wrap.
- req_ready[winner]=1 combinationally in this cycle, so the header is accepted the same cycle.
- Header fields are registered into data/keep/byte_cnt; grant_id<=winner; next state OFFER.
- If no request: stay in IDLE, all req_ready=0.

OFFER:
- valid_insert=1; outputs are stable until accepted (AXI rule).
- On ready_insert: go to WAIT_PKT.
- On ready_insert & last_evt in the same cycle (single-beat packet): go directly to IDLE and apply the completion actions.

WAIT_PKT:
- valid_insert=0; last_evt completes the packet: go to IDLE, rr_ptr<=(grant_id+1) mod NUM_REQ, pkt_cnt<=pkt_cnt+1.
- A last_evt seen in OFFER before header acceptance is ignored.

Latency and fairness:
- Latency: req_valid high in IDLE at cycle t gives valid_insert at t+1. After a completing last_evt at t, the next grant can occur at t+1.
- No requester waits more than NUM_REQ-1 packets once its req_valid is held high.

Boundary and edge cases:
- rr_ptr wraps NUM_REQ-1 to 0; pkt_cnt wraps all-ones to 0.
- Only one req_ready bit may ever be high, and only in IDLE.
- Reset mid-packet returns all state to reset values immediately; any header in flight is dropped.
- Requesters deasserting req_valid while not granted is legal.
- byte_insert_cnt is forwarded unmodified.

Decomposition:
- Shared package: DATA_WD, DATA_BYTE_WD, BYTE_CNT_WD defaults and the state encoding (IDLE=0, OFFER=1, WAIT_PKT=2).
- One sub-module: rr_priority_picker. Inputs are req vector and ptr; outputs are winner index and any_req. It is purely combinational and parameterised by NUM_REQ.

Test Plan:
- Single requester: req_valid=4'b0010, data=32'hA1B2C3D4, keep=4'hF, cnt=3. Expect req_ready=4'b0010 for 1 cycle, then valid_insert=1 with data_insert=32'hA1B2C3D4 and grant_id=1. Hold ready_insert=0 for 3 cycles: outputs stable. After ready_insert and then last_evt: pkt_cnt=1, busy=0.
- All four requesting continuously: grant order 0,1,2,3,0, with one packet of 3 beats each. pkt_cnt=5 after 5 packets.
- After a grant to requester 2, only requesters 0 and 3 request. Next grant is 3, then 0.
- Single-beat packet: ready_insert and last_evt in the same OFFER cycle. State returns to IDLE next cycle and pkt_cnt increments once.
- Spurious last_evt during OFFER before ready_insert is ignored. A later last_evt in WAIT_PKT completes the packet.
- rst_n pulsed low in WAIT_PKT. Outputs return to reset values asynchronously and rr_ptr=0, so the next grant goes to the lowest-index requester. Also preload pkt_cnt to 16'hFFFF and complete one packet: pkt_cnt wraps to 0.

Source files
------------

// File: rtl/axi_stream_header_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// axi_stream_header_arbiter_pkg
// Shared defaults and FSM state encoding for the header arbiter.
//   DFLT_DATA_WD      : default header/data width in bits
//   DFLT_DATA_BYTE_WD : default number of byte lanes
//   DFLT_BYTE_CNT_WD  : default width of the byte-count field
//   ST_IDLE/ST_OFFER/ST_WAIT_PKT : arbiter FSM states
// ----------------------------------------------------------------------------
package axi_stream_header_arbiter_pkg;

  localparam int DFLT_DATA_WD      = 32;
  localparam int DFLT_DATA_BYTE_WD = DFLT_DATA_WD / 8;
  localparam int DFLT_BYTE_CNT_WD  = $clog2(DFLT_DATA_BYTE_WD);

  localparam int STATE_WD = 2;

  // Plain constants rather than an enum so the encoding stays visible to
  // legacy tooling that inspects the state register directly.
  localparam logic [STATE_WD-1:0] ST_IDLE     = 2'd0;
  localparam logic [STATE_WD-1:0] ST_OFFER    = 2'd1;
  localparam logic [STATE_WD-1:0] ST_WAIT_PKT = 2'd2;

endpackage : axi_stream_header_arbiter_pkg

// File: rtl/axi_stream_header_arbiter_rr_priority_picker.sv
// ----------------------------------------------------------------------------
// rr_priority_picker
// Purely combinational round-robin search: returns the first set bit of req_i
// found scanning upward from ptr_i, wrapping from NUM_REQ-1 back to 0.
//   req_i     : request vector
//   ptr_i     : index with highest priority this cycle (< NUM_REQ)
//   winner_o  : index of the selected request (0 when none)
//   any_req_o : at least one request is set
// ----------------------------------------------------------------------------
module rr_priority_picker #(
  parameter int NUM_REQ   = 4,
  parameter int REQ_ID_WD = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [REQ_ID_WD-1:0] ptr_i,
  output logic [REQ_ID_WD-1:0] winner_o,
  output logic                 any_req_o
);

  always_comb begin
    // NOTE: every output gets a default before the loop; otherwise a path
    // with no request set would leave them unassigned and infer a latch.
    winner_o  = '0;
    any_req_o = 1'b0;
    // Scan from the farthest offset down to offset 0 so that the nearest
    // set bit (smallest offset from ptr_i) is the last one written and wins.
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      int idx;
      idx = (int'(ptr_i) + off) % NUM_REQ;
      if (req_i[idx]) begin
        winner_o  = REQ_ID_WD'(idx);
        any_req_o = 1'b1;
      end
    end
  end

endmodule : rr_priority_picker

// File: rtl/axi_stream_header_arbiter.sv
// ----------------------------------------------------------------------------
// axi_stream_header_arbiter
// Round-robin arbiter that funnels several header requesters onto the single
// insert-header channel of the header-insertion datapath. A grant is held for
// a whole packet: from header acceptance by the inserter until the last data
// beat is observed on the inserter's input stream.
//   req_valid/req_data/req_keep/req_byte_cnt : packed per-requester headers
//   req_ready       : one-hot accept pulse to the winner (IDLE only)
//   valid_insert, data_insert, keep_insert, byte_insert_cnt, ready_insert :
//                     registered header channel towards the inserter
//   mon_valid_in, mon_ready_in, mon_last_in : passive tap on inserter input
//   grant_id        : index of the current/most recent owner
//   busy            : a packet is being offered or is in flight
//   pkt_cnt         : completed packets, wraps
// ----------------------------------------------------------------------------
module axi_stream_header_arbiter
  import axi_stream_header_arbiter_pkg::*;
#(
  parameter int DATA_WD      = DFLT_DATA_WD,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
  parameter int NUM_REQ      = 4,
  parameter int REQ_ID_WD    = $clog2(NUM_REQ),
  parameter int PKT_CNT_WD   = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WD-1:0]      req_data,
  input  logic [NUM_REQ*DATA_BYTE_WD-1:0] req_keep,
  input  logic [NUM_REQ*BYTE_CNT_WD-1:0]  req_byte_cnt,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            valid_insert,
  output logic [DATA_WD-1:0]              data_insert,
  output logic [DATA_BYTE_WD-1:0]         keep_insert,
  output logic [BYTE_CNT_WD-1:0]          byte_insert_cnt,
  input  logic                            ready_insert,
  input  logic                            mon_valid_in,
  input  logic                            mon_ready_in,
  input  logic                            mon_last_in,
  output logic [REQ_ID_WD-1:0]            grant_id,
  output logic                            busy,
  output logic [PKT_CNT_WD-1:0]           pkt_cnt
);

  logic [STATE_WD-1:0]     state_q,    state_d;
  logic [REQ_ID_WD-1:0]    rr_ptr_q,   rr_ptr_d;
  logic [REQ_ID_WD-1:0]    grant_q,    grant_d;
  logic [DATA_WD-1:0]      data_q,     data_d;
  logic [DATA_BYTE_WD-1:0] keep_q,     keep_d;
  logic [BYTE_CNT_WD-1:0]  cnt_q,      cnt_d;
  logic [PKT_CNT_WD-1:0]   pkt_cnt_q,  pkt_cnt_d;

  logic [REQ_ID_WD-1:0]    winner;
  logic                    any_req;
  logic                    last_evt;
  logic [REQ_ID_WD-1:0]    ptr_after_grant;

  // Packet end as seen on the inserter's input handshake.
  assign last_evt = mon_valid_in & mon_ready_in & mon_last_in;

  // Owner after the current one, wrapping NUM_REQ-1 -> 0.
  assign ptr_after_grant = (grant_q == REQ_ID_WD'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

  rr_priority_picker #(
    .NUM_REQ   (NUM_REQ),
    .REQ_ID_WD (REQ_ID_WD)
  ) u_picker (
    .req_i     (req_valid),
    .ptr_i     (rr_ptr_q),
    .winner_o  (winner),
    .any_req_o (any_req)
  );

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    data_d    = data_q;
    keep_d    = keep_q;
    cnt_d     = cnt_q;
    pkt_cnt_d = pkt_cnt_q;
    req_ready = '0;

    case (state_q)
      ST_IDLE: begin
        // The accept pulse is combinational so the header is taken in the
        // same cycle the request is seen; it is captured here and offered
        // from registers from the next cycle on.
        if (any_req) begin
          req_ready[winner] = 1'b1;
          data_d  = req_data[int'(winner)*DATA_WD +: DATA_WD];
          keep_d  = req_keep[int'(winner)*DATA_BYTE_WD +: DATA_BYTE_WD];
          cnt_d   = req_byte_cnt[int'(winner)*BYTE_CNT_WD +: BYTE_CNT_WD];
          grant_d = winner;
          state_d = ST_OFFER;
        end
      end

      ST_OFFER: begin
        // last_evt before the header is accepted belongs to someone else's
        // traffic and is ignored; only an accept in the same cycle counts
        // it, which covers single-beat packets.
        if (ready_insert) begin
          if (last_evt) begin
            state_d   = ST_IDLE;
            rr_ptr_d  = ptr_after_grant;
            pkt_cnt_d = pkt_cnt_q + 1'b1;
          end else begin
            state_d = ST_WAIT_PKT;
          end
        end
      end

      ST_WAIT_PKT: begin
        if (last_evt) begin
          state_d   = ST_IDLE;
          rr_ptr_d  = ptr_after_grant;
          pkt_cnt_d = pkt_cnt_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      data_q    <= '0;
      keep_q    <= '0;
      cnt_q     <= '0;
      pkt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      data_q    <= data_d;
      keep_q    <= keep_d;
      cnt_q     <= cnt_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  assign valid_insert    = (state_q == ST_OFFER);
  assign busy            = (state_q != ST_IDLE);
  assign data_insert     = data_q;
  assign keep_insert     = keep_q;
  assign byte_insert_cnt = cnt_q;
  assign grant_id        = grant_q;
  assign pkt_cnt         = pkt_cnt_q;

endmodule : axi_stream_header_arbiter

// File: tb/tb_axi_stream_header_arbiter.sv
// ----------------------------------------------------------------------------
// tb_axi_stream_header_arbiter
// Directed self-checking bench for axi_stream_header_arbiter (NUM_REQ=4,
// DATA_WD=32). Inputs are driven on the falling edge, outputs sampled on the
// falling edge or shortly after it.
// ----------------------------------------------------------------------------
module tb_axi_stream_header_arbiter;

  localparam int DATA_WD      = 32;
  localparam int DATA_BYTE_WD = 4;
  localparam int BYTE_CNT_WD  = 2;
  localparam int NUM_REQ      = 4;
  localparam int REQ_ID_WD    = 2;
  localparam int PKT_CNT_WD   = 16;

  logic                            clk = 1'b0;
  logic                            rst_n;
  logic [NUM_REQ-1:0]              req_valid;
  logic [NUM_REQ*DATA_WD-1:0]      req_data;
  logic [NUM_REQ*DATA_BYTE_WD-1:0] req_keep;
  logic [NUM_REQ*BYTE_CNT_WD-1:0]  req_byte_cnt;
  logic [NUM_REQ-1:0]              req_ready;
  logic                            valid_insert;
  logic [DATA_WD-1:0]              data_insert;
  logic [DATA_BYTE_WD-1:0]         keep_insert;
  logic [BYTE_CNT_WD-1:0]          byte_insert_cnt;
  logic                            ready_insert;
  logic                            mon_valid_in;
  logic                            mon_ready_in;
  logic                            mon_last_in;
  logic [REQ_ID_WD-1:0]            grant_id;
  logic                            busy;
  logic [PKT_CNT_WD-1:0]           pkt_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  // Per-requester header table; requester 1 carries the header from the
  // single-requester scenario.
  logic [DATA_WD-1:0]      hdr_tbl  [NUM_REQ] = '{32'hC0DE_0000, 32'hA1B2_C3D4, 32'hC0DE_0002, 32'hC0DE_0003};
  logic [DATA_BYTE_WD-1:0] keep_tbl [NUM_REQ] = '{4'h1, 4'hF, 4'h7, 4'h3};
  logic [BYTE_CNT_WD-1:0]  cnt_tbl  [NUM_REQ] = '{2'd0, 2'd3, 2'd2, 2'd1};

  always #5 clk = ~clk;

  axi_stream_header_arbiter #(
    .DATA_WD      (DATA_WD),
    .DATA_BYTE_WD (DATA_BYTE_WD),
    .BYTE_CNT_WD  (BYTE_CNT_WD),
    .NUM_REQ      (NUM_REQ),
    .REQ_ID_WD    (REQ_ID_WD),
    .PKT_CNT_WD   (PKT_CNT_WD)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_keep        (req_keep),
    .req_byte_cnt    (req_byte_cnt),
    .req_ready       (req_ready),
    .valid_insert    (valid_insert),
    .data_insert     (data_insert),
    .keep_insert     (keep_insert),
    .byte_insert_cnt (byte_insert_cnt),
    .ready_insert    (ready_insert),
    .mon_valid_in    (mon_valid_in),
    .mon_ready_in    (mon_ready_in),
    .mon_last_in     (mon_last_in),
    .grant_id        (grant_id),
    .busy            (busy),
    .pkt_cnt         (pkt_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic set_mon(input logic v, input logic r, input logic l);
    mon_valid_in = v;
    mon_ready_in = r;
    mon_last_in  = l;
  endtask

  // Waits (bounded) for the header offer, accepts it, then streams `beats`
  // data beats with last on the final one. Returns the granted index and
  // header; finishes on the falling edge after the completing beat.
  task automatic do_packet(input int beats, output logic [REQ_ID_WD-1:0] gid,
                           output logic [DATA_WD-1:0] hdr);
    int n = 0;
    while (!valid_insert && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!valid_insert) check("offer_timeout", {31'd0, valid_insert}, 32'd1);
    gid = grant_id;
    hdr = data_insert;
    ready_insert = 1'b1;
    @(negedge clk);
    ready_insert = 1'b0;
    for (int b = 0; b < beats; b++) begin
      set_mon(1'b1, 1'b1, b == beats - 1);
      @(negedge clk);
    end
    set_mon(1'b0, 1'b0, 1'b0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [REQ_ID_WD-1:0] gid;
    logic [DATA_WD-1:0]   hdr;
    logic [REQ_ID_WD-1:0] exp_order [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    req_valid    = '0;
    ready_insert = 1'b0;
    set_mon(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < NUM_REQ; i++) begin
      req_data[i*DATA_WD +: DATA_WD]              = hdr_tbl[i];
      req_keep[i*DATA_BYTE_WD +: DATA_BYTE_WD]    = keep_tbl[i];
      req_byte_cnt[i*BYTE_CNT_WD +: BYTE_CNT_WD]  = cnt_tbl[i];
    end

    // ---- reset values ----
    rst_n = 1'b0;
    #12;
    check("rst_valid",   {31'd0, valid_insert}, 32'd0);
    check("rst_busy",    {31'd0, busy},         32'd0);
    check("rst_grant",   {30'd0, grant_id},     32'd0);
    check("rst_pkt_cnt", {16'd0, pkt_cnt},      32'd0);
    check("rst_data",    data_insert,           32'd0);
    check("rst_ready",   {28'd0, req_ready},    32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- single requester, held offer, then packet completion ----
    @(negedge clk);
    req_valid = 4'b0010;
    #1;
    check("t1_req_ready", {28'd0, req_ready}, 32'h2);
    @(negedge clk);
    check("t1_valid",  {31'd0, valid_insert},    32'd1);
    check("t1_data",   data_insert,              32'hA1B2C3D4);
    check("t1_keep",   {28'd0, keep_insert},     32'hF);
    check("t1_cnt",    {30'd0, byte_insert_cnt}, 32'd3);
    check("t1_grant",  {30'd0, grant_id},        32'd1);
    check("t1_busy",   {31'd0, busy},            32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t1_hold_valid", {31'd0, valid_insert}, 32'd1);
      check("t1_hold_data",  data_insert,           32'hA1B2C3D4);
      check("t1_hold_ready", {28'd0, req_ready},    32'd0);
    end
    req_valid    = '0;
    ready_insert = 1'b1;
    @(negedge clk);
    ready_insert = 1'b0;
    check("t1_wait_valid", {31'd0, valid_insert}, 32'd0);
    check("t1_wait_busy",  {31'd0, busy},         32'd1);
    set_mon(1'b1, 1'b1, 1'b1);
    @(negedge clk);
    set_mon(1'b0, 1'b0, 1'b0);
    check("t1_pkt_cnt", {16'd0, pkt_cnt}, 32'd1);
    check("t1_idle",    {31'd0, busy},    32'd0);

    // ---- all four requesting: order 0,1,2,3,0 ----
    apply_reset();
    req_valid = 4'hF;
    for (int p = 0; p < 5; p++) begin
      do_packet(3, gid, hdr);
      check("t2_grant", {30'd0, gid}, {30'd0, exp_order[p]});
      check("t2_hdr",   hdr,          hdr_tbl[exp_order[p]]);
    end
    req_valid = '0;
    check("t2_pkt_cnt", {16'd0, pkt_cnt}, 32'd5);

    // ---- after grant 2, only 0 and 3 request: 3 then 0 ----
    req_valid = 4'b0100;
    do_packet(1, gid, hdr);
    check("t3_grant2", {30'd0, gid}, 32'd2);
    req_valid = 4'b1001;
    do_packet(2, gid, hdr);
    check("t3_grant3", {30'd0, gid}, 32'd3);
    do_packet(2, gid, hdr);
    check("t3_grant0", {30'd0, gid}, 32'd0);
    req_valid = '0;
    check("t3_pkt_cnt", {16'd0, pkt_cnt}, 32'd8);

    // ---- single-beat packet: accept and last in the same cycle ----
    req_valid = 4'b0010;
    @(negedge clk);
    req_valid = '0;
    check("t4_grant", {30'd0, grant_id}, 32'd1);
    ready_insert = 1'b1;
    set_mon(1'b1, 1'b1, 1'b1);
    @(negedge clk);
    ready_insert = 1'b0;
    set_mon(1'b0, 1'b0, 1'b0);
    check("t4_busy",    {31'd0, busy},         32'd0);
    check("t4_valid",   {31'd0, valid_insert}, 32'd0);
    check("t4_pkt_cnt", {16'd0, pkt_cnt},      32'd9);
    @(negedge clk);
    check("t4_pkt_once", {16'd0, pkt_cnt}, 32'd9);

    // ---- spurious last during OFFER is ignored ----
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = '0;
    check("t5_grant", {30'd0, grant_id}, 32'd0);
    set_mon(1'b1, 1'b1, 1'b1);
    @(negedge clk);
    set_mon(1'b0, 1'b0, 1'b0);
    check("t5_still_offer", {31'd0, valid_insert}, 32'd1);
    check("t5_pkt_hold",    {16'd0, pkt_cnt},      32'd9);
    ready_insert = 1'b1;
    @(negedge clk);
    ready_insert = 1'b0;
    check("t5_wait_busy", {31'd0, busy},    32'd1);
    check("t5_wait_pkt",  {16'd0, pkt_cnt}, 32'd9);
    set_mon(1'b1, 1'b1, 1'b1);
    @(negedge clk);
    set_mon(1'b0, 1'b0, 1'b0);
    check("t5_pkt_cnt", {16'd0, pkt_cnt}, 32'd10);
    check("t5_idle",    {31'd0, busy},    32'd0);

    // ---- asynchronous reset in WAIT_PKT ----
    req_valid = 4'b1000;
    @(negedge clk);
    req_valid = '0;
    check("t6_grant3", {30'd0, grant_id}, 32'd3);
    ready_insert = 1'b1;
    @(negedge clk);
    ready_insert = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy",  {31'd0, busy},         32'd0);
    check("t6_rst_valid", {31'd0, valid_insert}, 32'd0);
    check("t6_rst_grant", {30'd0, grant_id},     32'd0);
    check("t6_rst_pkt",   {16'd0, pkt_cnt},      32'd0);
    check("t6_rst_data",  data_insert,           32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // rr_ptr was 1 before reset; a reset pointer must pick 0 over 3.
    req_valid = 4'b1001;
    #1;
    check("t6_req_ready", {28'd0, req_ready}, 32'h1);
    @(negedge clk);
    req_valid = '0;
    check("t6_grant0", {30'd0, grant_id}, 32'd0);

    // ---- pkt_cnt wrap from all-ones ----
    force dut.pkt_cnt_q = 16'hFFFF;
    ready_insert = 1'b1;
    @(negedge clk);
    ready_insert = 1'b0;
    release dut.pkt_cnt_q;
    set_mon(1'b1, 1'b1, 1'b1);
    @(negedge clk);
    set_mon(1'b0, 1'b0, 1'b0);
    check("t7_pkt_wrap", {16'd0, pkt_cnt}, 32'd0);
    check("t7_idle",     {31'd0, busy},    32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_axi_stream_header_arbiter
